// File: rtl/lz77_block_sequencer.sv
// Ping-pong block sequencer: fills one bank from the byte stream while the LZ77 engine compresses the other.
// Optional engine watchdog enabled by defining LZ_SEQ_WATCHDOG_EN.
module lz77_block_sequencer #(
    parameter int BLOCK_SIZE     = 64,
    parameter int ADDR_W         = 6,
    parameter int LEN_W          = 7,
    parameter int DATA_W         = 8,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              in_ready,
    output logic              buf_we,
    output logic              buf_bank,
    output logic [ADDR_W-1:0] buf_addr,
    output logic [DATA_W-1:0] buf_wdata,
    output logic              eng_start,
    output logic              eng_bank,
    output logic [LEN_W-1:0]  eng_len,
    input  logic              eng_done,
    output logic              blk_done,
    output logic              frame_done,
    output logic [15:0]       blk_count,
    output logic              busy,
    output logic              eng_err,
    output logic [1:0]        dbg_state
);

    // Input handshake: a byte transfers on any cycle where in_valid && in_ready;
    // in_ready depends only on the fullness of the bank currently being filled.
    typedef enum logic [1:0] {E_IDLE = 2'd0, E_RUN = 2'd1, E_RELEASE = 2'd2} e_state_t;

    e_state_t          state;
    logic [1:0]        full;
    logic [1:0]        lastflag;
    logic [LEN_W-1:0]  len [2];
    logic              wr_bank;
    logic              rd_bank;
    logic [ADDR_W-1:0] ptr;

    logic              accept;
    logic              blk_end;
    logic [LEN_W-1:0]  fill_len;
    logic              start_now;
    logic [LEN_W-1:0]  start_len;
    logic              wd_hit;
    logic              done_now;

    assign in_ready  = !full[wr_bank];
    assign accept    = in_valid && in_ready;
    assign blk_end   = accept && ((ptr == ADDR_W'(BLOCK_SIZE - 1)) || in_last);
    assign fill_len  = LEN_W'(ptr) + LEN_W'(1);

    assign buf_we    = accept;
    assign buf_bank  = wr_bank;
    assign buf_addr  = ptr;
    assign buf_wdata = accept ? in_data : '0;

    assign busy      = (|full) || (state != E_IDLE);
    assign dbg_state = state;

    // Bypass the just-completed block so the start pulse follows the last byte by one cycle.
    assign start_now = (state == E_IDLE) && (full[rd_bank] || (blk_end && (wr_bank == rd_bank)));
    assign start_len = full[rd_bank] ? len[rd_bank] : fill_len;
    assign done_now  = (state == E_RUN) && (eng_done || wd_hit);

`ifdef LZ_SEQ_WATCHDOG_EN
    logic [15:0] wd_cnt;
    assign wd_hit = (wd_cnt == 16'(TIMEOUT_CYCLES - 1));
`else
    assign wd_hit  = 1'b0;
    assign eng_err = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= E_IDLE;
            full       <= '0;
            lastflag   <= '0;
            len[0]     <= '0;
            len[1]     <= '0;
            wr_bank    <= 1'b0;
            rd_bank    <= 1'b0;
            ptr        <= '0;
            eng_start  <= 1'b0;
            eng_bank   <= 1'b0;
            eng_len    <= '0;
            blk_done   <= 1'b0;
            frame_done <= 1'b0;
            blk_count  <= '0;
`ifdef LZ_SEQ_WATCHDOG_EN
            wd_cnt     <= '0;
            eng_err    <= 1'b0;
`endif
        end else begin
            eng_start  <= 1'b0;
            blk_done   <= 1'b0;
            frame_done <= 1'b0;

            if (accept) begin
                ptr <= blk_end ? '0 : ptr + ADDR_W'(1);
            end
            if (blk_end) begin
                full[wr_bank]     <= 1'b1;
                len[wr_bank]      <= fill_len;
                lastflag[wr_bank] <= in_last;
                wr_bank           <= ~wr_bank;
            end

            case (state)
                E_IDLE: begin
                    if (start_now) begin
                        eng_start <= 1'b1;
                        eng_bank  <= rd_bank;
                        eng_len   <= start_len;
                        state     <= E_RUN;
                    end
                end
                E_RUN: begin
                    // Release pulses are registered on entry so they appear the cycle after eng_done.
                    if (done_now) begin
                        blk_done   <= 1'b1;
                        frame_done <= lastflag[rd_bank];
                        blk_count  <= blk_count + 16'd1;
                        state      <= E_RELEASE;
                    end
                end
                E_RELEASE: begin
                    full[rd_bank] <= 1'b0;
                    rd_bank       <= ~rd_bank;
                    state         <= E_IDLE;
                end
                default: state <= E_IDLE;
            endcase

`ifdef LZ_SEQ_WATCHDOG_EN
            if (state == E_RUN && !done_now) begin
                wd_cnt <= wd_cnt + 16'd1;
            end else begin
                wd_cnt <= '0;
            end
            if (state == E_RUN && wd_hit && !eng_done) begin
                eng_err <= 1'b1;
            end
`endif
        end
    end

endmodule

// File: tb/tb_lz77_block_sequencer.sv
// Directed bench for lz77_block_sequencer with a queue of expected engine starts (bank, len, last).
module tb_lz77_block_sequencer;

  localparam int LEN_W = 7;
  localparam int ADDR_W = 6;
  localparam int W = LEN_W + 2;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic [7:0]        in_data = '0;
  logic              in_last = 1'b0;
  logic              in_ready;
  logic              buf_we;
  logic              buf_bank;
  logic [ADDR_W-1:0] buf_addr;
  logic [7:0]        buf_wdata;
  logic              eng_start;
  logic              eng_bank;
  logic [LEN_W-1:0]  eng_len;
  logic              eng_done;
  logic              blk_done;
  logic              frame_done;
  logic [15:0]       blk_count;
  logic              busy;
  logic              eng_err;
  logic [1:0]        dbg_state;

  logic eng_done_auto = 1'b0;
  logic eng_done_man = 1'b0;
  assign eng_done = eng_done_auto | eng_done_man;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] exp_q[$];
  logic         exp_wr = 1'b0;
  int           exp_ptr = 0;
  logic         cur_last = 1'b0;
  logic         running = 1'b0;
  logic         eng_auto = 1'b0;
  int           eng_delay = 10;

  lz77_block_sequencer #(
    .BLOCK_SIZE(64), .ADDR_W(ADDR_W), .LEN_W(LEN_W), .DATA_W(8), .TIMEOUT_CYCLES(100)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
    .buf_we(buf_we), .buf_bank(buf_bank), .buf_addr(buf_addr), .buf_wdata(buf_wdata),
    .eng_start(eng_start), .eng_bank(eng_bank), .eng_len(eng_len), .eng_done(eng_done),
    .blk_done(blk_done), .frame_done(frame_done), .blk_count(blk_count),
    .busy(busy), .eng_err(eng_err), .dbg_state(dbg_state)
  );

  // clock / safety limit
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout obs=running exp=finished");
    $fatal(1, "simulation time limit");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // driver: one byte, bounded wait for in_ready, checks the buffer write in the accept cycle
  task automatic send_byte(input logic [7:0] d, input logic l);
    int waitc = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    #1;
    while (!in_ready && waitc < 2000) begin
      @(negedge clk);
      #1;
      waitc++;
    end
    if (!in_ready) begin
      chk("in_ready_timeout", 32'(in_ready), 32'd1);
      in_valid = 1'b0;
      in_last  = 1'b0;
      return;
    end
    chk("buf_we", 32'(buf_we), 32'd1);
    chk("buf_bank_addr", {buf_bank, buf_addr}, {exp_wr, ADDR_W'(exp_ptr)});
    chk("buf_wdata", 32'(buf_wdata), 32'(d));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    if (exp_ptr == 63 || l) begin
      exp_q.push_back({exp_wr, LEN_W'(exp_ptr + 1), l});
      exp_wr  = ~exp_wr;
      exp_ptr = 0;
    end else begin
      exp_ptr++;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    exp_q.delete();
    exp_wr  = 1'b0;
    exp_ptr = 0;
    running = 1'b0;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_outputs", {eng_start, blk_done, frame_done, busy, buf_we, eng_bank, eng_err},
        7'd0);
    chk("rst_blk_count", 32'(blk_count), 32'd0);
    chk("rst_eng_len", 32'(eng_len), 32'd0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((busy || running || exp_q.size() != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", 32'(busy || running), 32'd0);
  endtask

  task automatic pulse_done_manual();
    @(negedge clk);
    eng_done_man = 1'b1;
    @(negedge clk);
    eng_done_man = 1'b0;
    #1;
    chk("manual_blk_latency", 32'(blk_done), 32'd1);
  endtask

  // engine model: answers each start with a done pulse eng_delay cycles later
  initial begin
    forever begin
      @(negedge clk);
      if (eng_start && eng_auto && !rst) begin
        repeat (eng_delay) @(negedge clk);
        eng_done_auto = 1'b1;
        @(negedge clk);
        eng_done_auto = 1'b0;
        #1;
        chk("blk_latency", 32'(blk_done), 32'd1);
      end
    end
  end

  // scoreboard: pops an expected block per start, checks frame_done per release
  always @(negedge clk) begin
    if (!rst) begin
      if (eng_start) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_start", 32'(eng_start), 32'd0);
        end else begin
          logic [W-1:0] item;
          item = exp_q.pop_front();
          chk("eng_bank", 32'(eng_bank), 32'(item[W-1]));
          chk("eng_len", 32'(eng_len), 32'(item[W-2:1]));
          cur_last = item[0];
          running  = 1'b1;
        end
      end
      if (blk_done) begin
        chk("blk_done_expected", 32'(running), 32'd1);
        chk("frame_done", 32'(frame_done), 32'(cur_last));
        running = 1'b0;
      end
    end
  end

  initial begin
    int n;
    repeat (3) @(negedge clk);
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    chk("reset_blk_count", 32'(blk_count), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // 1: one full block ending the frame
    eng_auto  = 1'b1;
    eng_delay = 10;
    for (int i = 0; i < 64; i++) send_byte(8'(i), i == 63);
    @(negedge clk);
    chk("t1_start_latency", 32'(eng_start), 32'd1);
    wait_idle(200);
    chk("t1_blk_count", 32'(blk_count), 32'd1);

    // 2: 160 bytes, slow engine, both banks fill up
    do_reset();
    eng_delay = 200;
    for (int i = 0; i < 128; i++) send_byte(8'($urandom_range(0, 255)), 1'b0);
    @(negedge clk);
    chk("t2_both_full_in_ready", 32'(in_ready), 32'd0);
    chk("t2_both_full_busy", 32'(busy), 32'd1);
    for (int i = 128; i < 160; i++) send_byte(8'($urandom_range(0, 255)), i == 159);
    wait_idle(2000);
    chk("t2_blk_count", 32'(blk_count), 32'd3);

    // 3: single-byte frame
    eng_delay = 5;
    send_byte(8'hA5, 1'b1);
    @(negedge clk);
    chk("t3_start_latency", 32'(eng_start), 32'd1);
    chk("t3_eng_len", 32'(eng_len), 32'd1);
    wait_idle(100);
    chk("t3_blk_count", 32'(blk_count), 32'd4);

    // 4: stray eng_done while idle
    eng_auto = 1'b0;
    @(negedge clk);
    eng_done_man = 1'b1;
    @(negedge clk);
    eng_done_man = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("t4_no_blk_done", 32'(blk_done), 32'd0);
    end
    chk("t4_blk_count", 32'(blk_count), 32'd4);

    // 5: reset while running with bank 1 half filled
    for (int i = 0; i < 64; i++) send_byte(8'(i ^ 8'h5A), 1'b0);
    for (int i = 0; i < 32; i++) send_byte(8'(i), 1'b0);
    chk("t5_running_busy", 32'(busy), 32'd1);
    do_reset();
    for (int i = 0; i < 64; i++) send_byte(8'(8'hC0 + i), 1'b0);
    @(negedge clk);
    chk("t5_start_latency", 32'(eng_start), 32'd1);
    pulse_done_manual();
    wait_idle(100);
    chk("t5_blk_count", 32'(blk_count), 32'd1);

`ifdef LZ_SEQ_WATCHDOG_EN
    // 6: engine never answers, watchdog releases the bank
    do_reset();
    send_byte(8'h11, 1'b1);
    @(negedge clk);
    chk("t6_start", 32'(eng_start), 32'd1);
    n = 0;
    while (!blk_done && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("t6_wd_latency_ok", 32'(n >= 95 && n <= 110), 32'd1);
    chk("t6_eng_err", 32'(eng_err), 32'd1);
    repeat (5) @(negedge clk);
    chk("t6_eng_err_sticky", 32'(eng_err), 32'd1);
    chk("t6_blk_count", 32'(blk_count), 32'd1);
    do_reset();
`else
    n = 0;
    chk("no_wd_eng_err", 32'(eng_err), 32'd0);
`endif

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lz77_block_sequencer.md
Name: lz77_block_sequencer

Overview:
- Feeds the LZ77 match engine one block at a time from a byte stream, using a ping-pong pair of block buffers.
- One bank fills from the input while the engine compresses the other.
- For each full bank: issues a one-cycle start to the engine, waits for its done pulse, then releases the bank.
- Sits between the input byte interface and the match_control/datapath pair.

Parameters:
- BLOCK_SIZE, 64, bytes per block (power of two, ≥4).
- ADDR_W, 6, buffer address width, log2(BLOCK_SIZE).
- LEN_W, 7, block-length width, log2(BLOCK_SIZE)+1.
- DATA_W, 8, byte width.
- TIMEOUT_CYCLES, 65535, watchdog limit; used only with the optional feature.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  input byte valid.
- in_data  in  DATA_W  input byte.
- in_last  in  1  marks the final byte of the frame.
- in_ready  out  1  input can accept a byte.
- buf_we  out  1  buffer write strobe.
- buf_bank  out  1  bank being written.
- buf_addr  out  ADDR_W  write address.
- buf_wdata  out  DATA_W  write data.
- eng_start  out  1  one-cycle start pulse to the match engine.
- eng_bank  out  1  bank the engine must read; stable while engine runs.
- eng_len  out  LEN_W  valid bytes in that bank (1..BLOCK_SIZE).
- eng_done  in  1  engine done pulse.
- blk_done  out  1  one-cycle pulse when a bank is released.
- frame_done  out  1  one-cycle pulse when the last block of a frame is released.
- blk_count  out  16  blocks released since reset; wraps 0xFFFF→0.
- busy  out  1  any bank full or engine running.
- eng_err  out  1  sticky watchdog error (always 0 without the feature).

Behaviour:
- Reset (async): all outputs 0, both banks empty, wr_bank=0, rd_bank=0, write pointer 0, engine FSM in E_IDLE.
- Fill side:
  - in_ready = !full[wr_bank], combinational.
  - An accepted byte (in_valid&&in_ready) writes the same cycle: buf_we=1, buf_bank=wr_bank, buf_addr=ptr, buf_wdata=in_data. ptr increments.
  - If ptr==BLOCK_SIZE-1 or in_last: set full[wr_bank], len[wr_bank]=ptr+1, lastflag[wr_bank]=in_last, ptr←0, wr_bank toggles.
  - in_last on the BLOCK_SIZE-th byte gives len=BLOCK_SIZE with lastflag=1. No zero-length blocks exist.
- Engine FSM:
  - E_IDLE: if full[rd_bank], pulse eng_start for 1 cycle, latch eng_bank=rd_bank and eng_len=len[rd_bank], go E_RUN.
  - E_RUN: wait for eng_done; then go E_RELEASE. eng_done seen in E_IDLE or E_RELEASE is ignored.
  - E_RELEASE (1 cycle): clear full[rd_bank], pulse blk_done, pulse frame_done if lastflag[rd_bank], increment blk_count, toggle rd_bank, go E_IDLE.
- Latency:
  - Last byte accepted at cycle N → eng_start at N+1.
  - eng_done at cycle M → blk_done at M+1.
  - Next eng_start no earlier than M+2.
- Both banks full: in_ready=0 until E_RELEASE. The freed bank is fillable the cycle after the release.
- Simultaneous set of full[wr_bank] and clear of full[rd_bank]: legal because they are always different banks. Both take effect.
- eng_bank and eng_len hold their values after release until the next eng_start.
- busy = full[0]|full[1]|(state!=E_IDLE).
- Reset mid-block: partial data is discarded, no pulses are generated, and the engine must also be reset.

Optional Feature:
- Macro: LZ_SEQ_WATCHDOG_EN.
- With it defined:
  - A 16-bit counter runs in E_RUN.
  - If it reaches TIMEOUT_CYCLES without eng_done: set sticky eng_err, go E_RELEASE. The bank is released, blk_done pulses, frame_done follows lastflag.
  - eng_err clears only on rst.
- Without it: no counter; eng_err tied to 0; E_RUN waits indefinitely.

Test Plan:
- Stream 64 bytes 0x00..0x3F with in_last on byte 63 → bank 0 written at addr 0..63; eng_start with eng_bank=0, eng_len=64; eng_done 10 cycles later → blk_done and frame_done, blk_count=1.
- Stream 160 bytes, in_last on the final byte, engine done 200 cycles after each start → eng_len sequence 64, 64, 32; banks alternate 0, 1, 0; in_ready=0 while both banks full; frame_done only on the third release.
- Single byte 0xA5 with in_last → eng_len=1; eng_start one cycle after acceptance.
- eng_done pulsed in E_IDLE with no full bank → no blk_done, blk_count unchanged.
- Assert rst during E_RUN with bank 1 half-filled → all outputs 0 and in_ready=1 immediately; next 64 bytes go to bank 0 at addr 0.
- With LZ_SEQ_WATCHDOG_EN and TIMEOUT_CYCLES=100, never assert eng_done → eng_err=1 and blk_done pulse about 101 cycles after eng_start; eng_err stays 1 until rst.
